// File: rtl/rf_fifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_fifo_arbiter_if
//
// Bundles the signals between the FIFO controller, its two ingress
// requesters, the egress consumer and the external 16x32 register file.
//
//   in0_valid/in0_data/in0_ready : requester 0 handshake
//   in1_valid/in1_data/in1_ready : requester 1 handshake
//   out_valid/out_data/out_ready : egress handshake (head of queue)
//   rf_wa/rf_wen/rf_din          : storage write port
//   rf_ra/rf_dout                : storage read port (rf_dout combinational)
//
// Modports:
//   master : the controller side (drives readies, egress data, storage port)
//   slave  : the environment side (requesters, consumer, storage)
// -----------------------------------------------------------------------------
interface rf_fifo_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          in0_valid;
    logic [DW-1:0] in0_data;
    logic          in0_ready;
    logic          in1_valid;
    logic [DW-1:0] in1_data;
    logic          in1_ready;

    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    logic [AW-1:0] rf_wa;
    logic          rf_wen;
    logic [DW-1:0] rf_din;
    logic [AW-1:0] rf_ra;
    logic [DW-1:0] rf_dout;

    modport master (
        input  in0_valid, in0_data, in1_valid, in1_data, out_ready, rf_dout,
        output in0_ready, in1_ready, out_valid, out_data,
               rf_wa, rf_wen, rf_din, rf_ra
    );

    modport slave (
        output in0_valid, in0_data, in1_valid, in1_data, out_ready, rf_dout,
        input  in0_ready, in1_ready, out_valid, out_data,
               rf_wa, rf_wen, rf_din, rf_ra
    );
endinterface

// File: rtl/rf_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// rf_fifo_arbiter
//
// Runs an external 16x32 register file as a shared packet-word queue.
// Two ingress requesters are round-robin arbitrated onto the single write
// port; the head word is presented on a valid/ready egress stream.
//
// Ports:
//   clk         : clock, all state updates on posedge
//   rst_n       : synchronous active-low reset
//   bus         : rf_fifo_arbiter_if.master (ingress, egress, storage port)
//   count       : occupancy 0..2**AW (registered)
//   full        : count == 2**AW
//   empty       : count == 0
//   almost_full : count >= AFULL_THRESH
// -----------------------------------------------------------------------------
module rf_fifo_arbiter #(
    parameter int DW           = 32,
    parameter int AW           = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_fifo_arbiter_if.master      bus,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full
);
    localparam logic [AW:0] DEPTH     = (AW+1)'(1 << AW);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL_THRESH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    // Index of the port granted most recently; the other port wins a tie.
    logic          last_grant;

    logic          grant0;
    logic          grant1;
    logic          push;
    logic          pop;
    logic [DW-1:0] wr_data;

    // Status comes from registered count only, so none of it depends
    // combinationally on the handshake inputs.
    assign full        = (count == DEPTH);
    assign empty       = (count == '0);
    assign almost_full = (count >= AFULL_CNT);

    // Write arbitration. Grants are suppressed while reset is asserted so a
    // requester never sees a handshake that the reset edge throws away.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !full) begin
            if (bus.in0_valid && bus.in1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.in0_valid;
                grant1 = bus.in1_valid;
            end
        end
    end

    assign push    = grant0 | grant1;
    assign pop     = !empty && bus.out_ready;
    assign wr_data = grant1 ? bus.in1_data : bus.in0_data;

    assign bus.in0_ready = grant0;
    assign bus.in1_ready = grant1;

    // The storage array itself lives outside this block and is never
    // cleared; words left over from before a reset are unreachable because
    // count restarts at zero.
    assign bus.rf_wen = push;
    assign bus.rf_wa  = wr_ptr;
    assign bus.rf_din = wr_data;
    assign bus.rf_ra  = rd_ptr;

    // Head word comes straight from the combinational read port. rd_ptr only
    // moves on a pop, so out_data is stable while the consumer stalls.
    assign bus.out_valid = !empty;
    assign bus.out_data  = bus.rf_dout;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_grant <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_grant <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push is already blocked at full and pop at empty, so the
            // counter cannot leave 0..DEPTH.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
